// File: rtl/fxp_pkg.sv
// fxp_pkg: shared FSM state type and Q4.4 format constants for the fixed-point accumulator
package fxp_pkg;

    localparam int FRAC_BITS = 4;
    localparam int PROD_W    = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

endpackage

// File: rtl/fxp_sat_trunc.sv
// fxp_sat_trunc: narrows the accumulator to OUT_W bits; clamps when FXP_ACC_SAT_EN is defined, wraps otherwise
module fxp_sat_trunc #(
    parameter int IN_W  = 10,
    parameter int OUT_W = 8
) (
    input  logic [IN_W-1:0]  acc,
    output logic [OUT_W-1:0] data,
    output logic             ovf
);

    // Any set bit at or above OUT_W means the sum does not fit the output range
    assign ovf = |(acc >> OUT_W);

`ifdef FXP_ACC_SAT_EN
    assign data = ovf ? '1 : OUT_W'(acc);
`else
    assign data = OUT_W'(acc);
`endif

endmodule

// File: rtl/fixed_point_accumulator.sv
// fixed_point_accumulator: sums groups of unsigned Q4.4 products (closed by count or in_last); FXP_ACC_SAT_EN selects saturating output
module fixed_point_accumulator #(
    parameter int PROD_W    = 8,
    parameter int NUM_TERMS = 4,
    parameter int OUT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PROD_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_ovf,
    output logic              out_valid,
    input  logic              out_ready
);

    import fxp_pkg::*;

    localparam int ACC_W = PROD_W + $clog2(NUM_TERMS);
    localparam int CNT_W = $clog2(NUM_TERMS + 1);

    state_t           state, state_nx;
    logic [ACC_W-1:0] acc, acc_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             take, close;

    assign in_ready  = state != DONE;
    assign out_valid = state == DONE;
    assign take      = in_valid && in_ready;
    assign close     = in_last || (cnt == CNT_W'(NUM_TERMS - 1));

    // Accept a term into the running sum, or release the finished group on handshake
    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        if (take) begin
            acc_nx   = acc + ACC_W'(in_data);
            cnt_nx   = cnt + 1'b1;
            state_nx = close ? DONE : ACCUM;
        end
        if (out_valid && out_ready) begin
            state_nx = IDLE;
            acc_nx   = '0;
            cnt_nx   = '0;
        end
    end

    // State, sum and term count; reset discards any partial group
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
        end
    end

    fxp_sat_trunc #(
        .IN_W (ACC_W),
        .OUT_W(OUT_W)
    ) u_sat_trunc (
        .acc (acc),
        .data(out_data),
        .ovf (out_ovf)
    );

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// tb_fixed_point_accumulator: directed vectors for the fixed-point accumulator (expects FXP_ACC_SAT_EN as built)
module tb_fixed_point_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_ovf;
    logic       out_valid;
    logic       out_ready;

    int n_chk  = 0;
    int n_fail = 0;

    fixed_point_accumulator #(
        .PROD_W   (8),
        .NUM_TERMS(4),
        .OUT_W    (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one term for a single edge; returns 1 time unit after that edge
    task automatic send(input logic [7:0] d, input logic last);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        check("ready_before_term", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic result(input string tag, input logic [7:0] d, input logic o);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, d);
        check({tag, "_ovf"}, out_ovf, o);
    endtask

    task automatic drained(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_idle_valid"}, out_valid, 0);
        check({tag, "_idle_ready"}, in_ready, 1);
    endtask

    logic [7:0] ovf_data;

    initial begin
`ifdef FXP_ACC_SAT_EN
        ovf_data = 8'hFF;
`else
        ovf_data = 8'h10;
`endif
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_ovf", out_ovf, 0);
        check("rst_ready", in_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full group: 4 x 1.25 = 5.0, valid exactly one cycle after the 4th term
        repeat (3) send(8'h14, 1'b0);
        check("full_not_early", out_valid, 0);
        send(8'h14, 1'b0);
        result("full", 8'h50, 1'b0);
        drained("full");

        // Early close after two terms
        send(8'h24, 1'b0);
        check("early_not_early", out_valid, 0);
        send(8'h60, 1'b1);
        result("early", 8'h84, 1'b0);
        drained("early");

        // Overflow: 4 x 0xC4 = 0x310
        repeat (4) send(8'hC4, 1'b0);
        result("ovf", ovf_data, 1'b1);
        drained("ovf");

        // Backpressure: held result, terms offered but refused
        out_ready = 1'b0;
        repeat (4) send(8'h11, 1'b0);
        in_data  = 8'h55;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, 8'h44);
            check("bp_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drained("bp");

        // One-term group from IDLE; also shows no refused term leaked in
        send(8'h30, 1'b1);
        result("one", 8'h30, 1'b0);
        drained("one");

        // Reset in the middle of a group
        repeat (2) send(8'h10, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", out_data, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        #1;
        rst_n = 1'b1;
        repeat (3) send(8'h10, 1'b0);
        check("post_rst_not_early", out_valid, 0);
        send(8'h10, 1'b0);
        result("post_rst", 8'h40, 1'b0);
        drained("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fixed_point_accumulator.md
FIXED_POINT_ACCUMULATOR -- requirements
Module: fixed_point_accumulator

Interface
REQ-001 SHALL have parameter PROD_W, default 8, meaning input product width (unsigned Q4.4).
REQ-002 SHALL have parameter NUM_TERMS, default 4, meaning products per group (legal range 2..16).
REQ-003 SHALL have parameter OUT_W, default 8, meaning result width (unsigned Q4.4, same fraction bits as the input).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1, meaning the asynchronous, active-low reset.
REQ-006 SHALL have port in_data, input, PROD_W, meaning the multiplier Product.
REQ-007 SHALL have port in_valid, input, 1, meaning in_data is valid.
REQ-008 SHALL have port in_last, input, 1, meaning the current term closes the group early.
REQ-009 SHALL have port in_ready, output, 1, meaning the block accepts a term.
REQ-010 SHALL have port out_data, output, OUT_W, meaning the group sum.
REQ-011 SHALL have port out_ovf, output, 1, meaning the group sum exceeded the OUT_W range.
REQ-012 SHALL have port out_valid, output, 1, meaning out_data/out_ovf are valid.
REQ-013 SHALL have port out_ready, input, 1, meaning the consumer takes the result.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM and DONE.
REQ-015 SHALL accept a term only on in_valid && in_ready, with in_ready = (state != DONE).
REQ-016 SHALL, on acceptance, add in_data, zero-extended, into an internal accumulator of width PROD_W+$clog2(NUM_TERMS), which cannot overflow.
REQ-017 SHALL, on accepting the first term in IDLE, go to ACCUM and set the term count to 1.
REQ-018 SHALL go to DONE when the accepted term is the NUM_TERMS-th or carries in_last=1; in_last on the first term closes a one-term group.
REQ-019 SHALL assert out_valid in the cycle after the closing term is accepted (latency 1), and only in DONE.
REQ-020 SHALL hold out_data/out_ovf stable while out_valid && !out_ready.
REQ-021 SHALL, on out_valid && out_ready, clear the accumulator and count and return to IDLE; the next term is accepted no earlier than the following cycle.
REQ-022 SHALL set out_ovf=1 when the accumulator value exceeds 2^OUT_W-1, else 0.
REQ-023 SHALL ignore in_last when in_valid=0.

Reset
REQ-024 SHALL, on rst_n low at any time including mid-group, asynchronously force the state to IDLE and the accumulator and count to 0.
REQ-025 SHALL drive these values during reset: out_valid=0, out_data=0, out_ovf=0, in_ready=1.
REQ-026 SHALL, after reset deassertion, begin a fresh group with no partial result leaking from the interrupted group.

Configuration
REQ-027 SHALL use the macro FXP_ACC_SAT_EN.
REQ-028 SHALL, with FXP_ACC_SAT_EN defined, clamp out_data to 2^OUT_W-1 when out_ovf=1.
REQ-029 SHALL, without FXP_ACC_SAT_EN, set out_data to the accumulator's low OUT_W bits (wrap); out_ovf is still reported.

Structure
REQ-030 SHALL place the FSM state enum (IDLE/ACCUM/DONE) and the Q-format constants (FRAC_BITS=4, PROD_W=8) in the shared package fxp_pkg.
REQ-031 SHALL contain one sub-module, fxp_sat_trunc, performing the accumulator-to-OUT_W conversion (clamp or wrap, plus the ovf flag); the remaining logic is flat.

Verification
REQ-032 SHALL cover a full group: 4 terms of 0x14 (1.25) with out_ready=1 -> out_data=0x50 (5.0), out_ovf=0, out_valid one cycle after the 4th term.
REQ-033 SHALL cover an early close: 0x24 then 0x60 with in_last=1 -> out_data=0x84, group closed after 2 terms.
REQ-034 SHALL cover overflow: 4 terms of 0xC4 (12.25) -> sum 0x310, out_ovf=1, out_data=0xFF with FXP_ACC_SAT_EN and 0x10 without.
REQ-035 SHALL cover backpressure: out_ready low for 5 cycles in DONE -> out_data stable, in_ready=0, in_valid terms not accepted; after release, in_ready=1 the next cycle.
REQ-036 SHALL cover reset mid-group: 2 terms of 0x10, then rst_n pulsed, then 4 terms of 0x10 -> out_data=0x40 (no carry-over).
REQ-037 SHALL cover a one-term group: a single 0x30 with in_last=1 from IDLE -> out_data=0x30, out_ovf=0.
